ifetch_queue: RTL and testbench

Instruction prefetch queue sitting directly upstream of the instruction fetcher. It issues 64-bit doubleword reads to instruction memory and buffers the returned halfwords in a ring. It presents the fetcher with a 64-bit window of the next four halfwords starting at the current fetch PC, and retires however many halfwords (0–4) the fetcher consumes each cycle. A redirect from branch/exception logic flushes the queue and restarts fetch at any halfword-aligned PC.

---
 rtl/v850_pkg.sv | 10 +
 rtl/ifq_ring.sv | 55 +++++
 rtl/ifetch_queue.sv | 114 +++++++++++
 tb/tb_ifetch_queue.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/v850_pkg.sv
// Shared types and constants for the v850 instruction fetch path.
package v850_pkg;

   localparam int PC_W      = 25;
   localparam int HW_PER_DW = 4;

   typedef logic [15:0]     halfword_t;
   typedef logic [PC_W-3:0] dword_addr_t;

endpackage

// File: rtl/ifq_ring.sv
// Halfword ring buffer: 4-wide read window at head, up-to-4-wide write at tail.
module ifq_ring
   import v850_pkg::*;
#(
   parameter int DEPTH = 16,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = PW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          wr_en,
   input  logic [1:0]    wr_skip,
   input  logic [63:0]   wr_data,
   input  logic [2:0]    rd_eff,
   output logic [63:0]   win,
   output logic [CW-1:0] count
);

   halfword_t         mem [DEPTH];
   logic [PW-1:0]     head_reg;
   logic [PW-1:0]     tail_reg;
   logic [CW-1:0]     count_reg;
   logic [2:0]        push;

   assign push  = wr_en ? (3'(HW_PER_DW) - {1'b0, wr_skip}) : 3'd0;
   assign count = count_reg;

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         head_reg  <= head_reg + PW'(rd_eff);
         tail_reg  <= tail_reg + PW'(push);
         count_reg <= count_reg + CW'(push) - CW'(rd_eff);
      end
   end

   // Halfwords below wr_skip are dropped; the rest pack contiguously from tail.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < HW_PER_DW; i++) begin
            if (i >= int'(wr_skip))
               mem[tail_reg + PW'(i) - PW'(wr_skip)] <= wr_data[16*i +: 16];
         end
      end
   end

   for (genvar gi = 0; gi < HW_PER_DW; gi++) begin : g_win
      assign win[16*gi +: 16] = mem[head_reg + PW'(gi)];
   end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: one outstanding doubleword read, redirect flush/discard.
module ifetch_queue
   import v850_pkg::*;
#(
   parameter int PC_W     = 25,
   parameter int DEPTH    = 16,
   parameter int RESET_PC = 0
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            mem_req_o,
   output logic [PC_W-3:0] mem_addr_o,
   input  logic            mem_ack_i,
   input  logic [63:0]     mem_rdata_i,
   output logic [63:0]     win_o,
   output logic [2:0]      win_cnt_o,
   output logic [PC_W-1:0] pc_o,
   input  logic [2:0]      consume_i,
   input  logic            redirect_i,
   input  logic [PC_W-1:0] redirect_pc_i
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);

   logic            req_reg,     req_next;
   logic [PC_W-3:0] addr_reg,    addr_next;
   logic [PC_W-3:0] fetch_reg,   fetch_next;
   logic [1:0]      lo_reg,      lo_next;
   logic            first_reg,   first_next;
   logic            discard_reg, discard_next;
   logic [PC_W-1:0] pc_reg,      pc_next;

   logic [CW-1:0]   count;
   logic [2:0]      eff;
   logic            fill;
   logic            room;

   assign mem_req_o  = req_reg;
   assign mem_addr_o = addr_reg;
   assign pc_o       = pc_reg;
   assign win_cnt_o  = (count >= CW'(4)) ? 3'd4 : count[2:0];

   assign eff  = redirect_i ? 3'd0 : ((consume_i > win_cnt_o) ? win_cnt_o : consume_i);
   assign fill = mem_ack_i && req_reg && !discard_reg && !redirect_i;
   // Space check uses the pre-consume count; a redirect empties the ring.
   assign room = redirect_i || (count <= CW'(DEPTH - HW_PER_DW));

   always_comb begin
      req_next     = req_reg;
      addr_next    = addr_reg;
      fetch_next   = fetch_reg;
      lo_next      = lo_reg;
      first_next   = first_reg;
      discard_next = discard_reg;
      pc_next      = pc_reg + PC_W'(eff);

      if (req_reg && mem_ack_i) begin
         req_next     = 1'b0;
         discard_next = 1'b0;
      end
      if (fill) begin
         fetch_next = fetch_reg + 1'b1;
         first_next = 1'b0;
      end
      if (redirect_i) begin
         pc_next    = redirect_pc_i;
         fetch_next = redirect_pc_i[PC_W-1:2];
         lo_next    = redirect_pc_i[1:0];
         first_next = 1'b1;
         if (req_reg && !mem_ack_i)
            discard_next = 1'b1;
      end
      if (!req_reg && room) begin
         req_next  = 1'b1;
         addr_next = fetch_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         req_reg     <= 1'b0;
         addr_reg    <= RST_PC[PC_W-1:2];
         fetch_reg   <= RST_PC[PC_W-1:2];
         lo_reg      <= RST_PC[1:0];
         first_reg   <= 1'b1;
         discard_reg <= 1'b0;
         pc_reg      <= RST_PC;
      end else begin
         req_reg     <= req_next;
         addr_reg    <= addr_next;
         fetch_reg   <= fetch_next;
         lo_reg      <= lo_next;
         first_reg   <= first_next;
         discard_reg <= discard_next;
         pc_reg      <= pc_next;
      end
   end

   ifq_ring #(
      .DEPTH (DEPTH)
   ) u_ring (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (redirect_i),
      .wr_en   (fill),
      .wr_skip (first_reg ? lo_reg : 2'd0),
      .wr_data (mem_rdata_i),
      .rd_eff  (eff),
      .win     (win_o),
      .count   (count)
   );

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue against a memory whose halfword n holds n[15:0].
module tb_ifetch_queue;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_req;
   logic [22:0] mem_addr;
   logic        mem_ack;
   logic [63:0] mem_rdata;
   logic [63:0] win;
   logic [2:0]  win_cnt;
   logic [24:0] pc;
   logic [2:0]  consume;
   logic        redirect;
   logic [24:0] redirect_pc;

   logic        auto_ack;
   logic        manual_ack;
   int          total = 0;
   int          bad   = 0;

   always #5 clk = ~clk;

   function automatic logic [15:0] hw(input logic [24:0] p);
      return p[15:0];
   endfunction

   function automatic logic [63:0] dw(input logic [22:0] a);
      logic [24:0] b;
      b = {a, 2'b00};
      return {hw(b + 25'd3), hw(b + 25'd2), hw(b + 25'd1), hw(b)};
   endfunction

   assign mem_ack   = (auto_ack & mem_req) | manual_ack;
   assign mem_rdata = dw(mem_addr);

   ifetch_queue #(
      .PC_W     (25),
      .DEPTH    (16),
      .RESET_PC (0)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .mem_req_o     (mem_req),
      .mem_addr_o    (mem_addr),
      .mem_ack_i     (mem_ack),
      .mem_rdata_i   (mem_rdata),
      .win_o         (win),
      .win_cnt_o     (win_cnt),
      .pc_o          (pc),
      .consume_i     (consume),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
         else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
         end
   endtask

   task automatic wait_req(input string tag);
      int n = 0;
      while (mem_req !== 1'b1 && n < 8) begin
         step();
         n++;
      end
      chk(tag, 64'(mem_req), 64'd1);
   endtask

   initial begin
      logic [24:0] exp_pc;
      logic [22:0] exp_addr;
      int          exp_count;
      int          exp_wc;
      int          eff;
      logic        push;

      rst_n = 1'b0; consume = 3'd0; redirect = 1'b0; redirect_pc = '0;
      auto_ack = 1'b1; manual_ack = 1'b0;
      step(); step();
      chk("rst_req", 64'(mem_req), 64'd0);
      chk("rst_addr", 64'(mem_addr), 64'd0);
      chk("rst_wcnt", 64'(win_cnt), 64'd0);
      chk("rst_pc", 64'(pc), 64'd0);

      // First request and zero-wait fill.
      rst_n = 1'b1;
      step();
      chk("first_req", 64'(mem_req), 64'd1);
      chk("first_addr", 64'(mem_addr), 64'd0);
      step();
      chk("fill_wcnt", 64'(win_cnt), 64'd4);
      chk("fill_win", win, 64'h0003_0002_0001_0000);
      chk("fill_pc", 64'(pc), 64'd0);
      for (int i = 0; i < 10; i++) step();
      chk("full_noreq", 64'(mem_req), 64'd0);
      chk("full_win", win, 64'h0003_0002_0001_0000);
      $display("tx fill-to-full done pc=%h", pc);

      // Redirect to odd PC 7: first fill keeps only halfword 3 of dword 1.
      redirect = 1'b1; redirect_pc = 25'd7;
      step();
      redirect = 1'b0;
      chk("rd7_wcnt0", 64'(win_cnt), 64'd0);
      chk("rd7_pc", 64'(pc), 64'd7);
      chk("rd7_req", 64'(mem_req), 64'd1);
      chk("rd7_addr", 64'(mem_addr), 64'd1);
      step();
      chk("rd7_wcnt1", 64'(win_cnt), 64'd1);
      chk("rd7_hw", 64'(win[15:0]), 64'd7);
      chk("rd7_pc2", 64'(pc), 64'd7);
      step(); step();
      chk("rd7_wcnt4", 64'(win_cnt), 64'd4);
      chk("rd7_win", win, 64'h000A_0009_0008_0007);
      $display("tx redirect pc=7 done");

      // Redirect while a request to dword 5 is pending; its data must be dropped.
      auto_ack = 1'b0;
      redirect = 1'b1; redirect_pc = 25'd20;
      step();
      chk("pend_req", 64'(mem_req), 64'd1);
      chk("pend_addr", 64'(mem_addr), 64'd5);
      redirect_pc = 25'h40;
      step();
      redirect = 1'b0;
      chk("disc_req", 64'(mem_req), 64'd1);
      chk("disc_addr", 64'(mem_addr), 64'd5);
      chk("disc_wcnt", 64'(win_cnt), 64'd0);
      chk("disc_pc", 64'(pc), 64'h40);
      step(); step();
      chk("disc_hold", 64'(mem_addr), 64'd5);
      manual_ack = 1'b1;
      step();
      manual_ack = 1'b0;
      chk("disc_drop_wcnt", 64'(win_cnt), 64'd0);
      chk("disc_drop_req", 64'(mem_req), 64'd0);
      step();
      chk("disc_newreq", 64'(mem_req), 64'd1);
      chk("disc_newaddr", 64'(mem_addr), 64'd16);
      auto_ack = 1'b1;
      step();
      chk("disc_fill_wcnt", 64'(win_cnt), 64'd4);
      chk("disc_fill_win", win, 64'h0043_0042_0041_0040);
      $display("tx discard done");

      // Streaming across ring and fetch-address wrap with consume 1,2,3,4.
      redirect = 1'b1; redirect_pc = 25'h1FF_FFF0;
      step();
      redirect = 1'b0;
      exp_pc = 25'h1FF_FFF0; exp_addr = 23'h7F_FFFC; exp_count = 0;
      for (int t = 0; t < 40; t++) begin
         consume = 3'((t % 4) + 1);
         exp_wc = (exp_count > 4) ? 4 : exp_count;
         chk("str_pc", 64'(pc), 64'(exp_pc));
         chk("str_wcnt", 64'(win_cnt), 64'(exp_wc));
         for (int j = 0; j < 4; j++)
            if (j < exp_wc) chk("str_hw", 64'(win[16*j +: 16]), 64'(hw(exp_pc + 25'(j))));
         push = mem_req && mem_ack;
         if (mem_req) chk("str_addr", 64'(mem_addr), 64'(exp_addr));
         eff = (int'(consume) > exp_wc) ? exp_wc : int'(consume);
         exp_count = exp_count + (push ? 4 : 0) - eff;
         exp_pc = exp_pc + 25'(eff);
         if (push) exp_addr = exp_addr + 23'd1;
         if (push) $display("tx stream ack addr=%h pc=%h", mem_addr, pc);
         step();
      end
      consume = 3'd0;

      // Over-consume while an ack lands the same cycle.
      redirect = 1'b1; redirect_pc = 25'd2;
      step();
      redirect = 1'b0;
      auto_ack = 1'b0;
      wait_req("oc_req0");
      chk("oc_addr0", 64'(mem_addr), 64'd0);
      manual_ack = 1'b1;
      step();
      manual_ack = 1'b0;
      chk("oc_wcnt2", 64'(win_cnt), 64'd2);
      chk("oc_pc2", 64'(pc), 64'd2);
      chk("oc_win2", 64'(win[31:0]), 64'h0003_0002);
      wait_req("oc_req1");
      chk("oc_addr1", 64'(mem_addr), 64'd1);
      consume = 3'd4; manual_ack = 1'b1;
      step();
      consume = 3'd0; manual_ack = 1'b0;
      chk("oc_wcnt4", 64'(win_cnt), 64'd4);
      chk("oc_pc4", 64'(pc), 64'd4);
      chk("oc_win4", win, 64'h0007_0006_0005_0004);
      $display("tx over-consume done");

      // Reset while a request is pending; a late ack is ignored.
      wait_req("mr_req");
      chk("mr_addr", 64'(mem_addr), 64'd2);
      rst_n = 1'b0;
      step();
      chk("mr_req0", 64'(mem_req), 64'd0);
      chk("mr_wcnt", 64'(win_cnt), 64'd0);
      chk("mr_pc", 64'(pc), 64'd0);
      chk("mr_addr0", 64'(mem_addr), 64'd0);
      rst_n = 1'b1; manual_ack = 1'b1;
      step();
      manual_ack = 1'b0;
      chk("late_wcnt", 64'(win_cnt), 64'd0);
      chk("late_req", 64'(mem_req), 64'd1);
      chk("late_addr", 64'(mem_addr), 64'd0);
      step();
      chk("late_wcnt2", 64'(win_cnt), 64'd0);
      $display("tx reset mid-request done");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
